// File: rtl/gf180mcu_mux2_arbiter.sv
// ---------------------------------------------------------------------------
// gf180mcu_mux2_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter that owns the select line of a row of
//   2:1 mux cells, sharing one downstream channel between sources A and B.
//   Sel only moves while no grant is live. Every change of source passes
//   through a one-cycle SWITCH state with no grant (break-before-make), so
//   the mux never carries a changing selection under an active grant.
//
// Optional feature (compile-time macro MUX2_ARB_TIMEOUT_EN):
//   When defined, a grant held for HOLD_MAX cycles while the other side is
//   requesting is forcibly released. When undefined the hold counter is not
//   built and HOLD_MAX / CNT_W have no effect.
//
// Ports:
//   CLK   in   clock, all state changes on the rising edge
//   RST   in   synchronous active-high reset
//   ReqA  in   level request from source A (held high until done)
//   ReqB  in   level request from source B (held high until done)
//   GntA  out  registered grant to A
//   GntB  out  registered grant to B
//   Sel   out  registered mux select (0 = A, 1 = B)
//   Busy  out  registered GntA | GntB
// ---------------------------------------------------------------------------
module gf180mcu_mux2_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic ReqA,
  input  logic ReqB,
  output logic GntA,
  output logic GntB,
  output logic Sel,
  output logic Busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_GNT_A  = 2'd2,
    ST_GNT_B  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_sel;
  logic   w_sel_next;
  logic   r_rr;          // round-robin pointer: 0 = A preferred, 1 = B preferred
  logic   w_rr_next;
  logic   r_gnt_a;
  logic   r_gnt_b;
  logic   r_busy;
  logic   w_winner;      // 0 = A, 1 = B; only meaningful when a request is up
  logic   w_release_a;
  logic   w_release_b;

  // Lone requester wins outright; a tie goes to the side rr_ptr favours.
  assign w_winner = (ReqA && !ReqB) ? 1'b0 :
                    (ReqB && !ReqA) ? 1'b1 : r_rr;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_hold_cnt;
  logic             w_expired;
  logic             w_in_gnt;
  logic             w_gnt_entry;

  assign w_expired   = (r_hold_cnt == HOLD_LAST);
  assign w_in_gnt    = (r_state == ST_GNT_A) || (r_state == ST_GNT_B);
  assign w_gnt_entry = !w_in_gnt &&
                       ((w_state_next == ST_GNT_A) || (w_state_next == ST_GNT_B));

  // Counts granted cycles: 0 in the first granted cycle, saturating.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold_cnt <= '0;
    end else if (w_gnt_entry) begin
      r_hold_cnt <= '0;
    end else if (w_in_gnt && (r_hold_cnt != CNT_SAT)) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  // Preemption only when the other side is actually waiting.
  assign w_release_a = !ReqA || (w_expired && ReqB);
  assign w_release_b = !ReqB || (w_expired && ReqA);
`else
  assign w_release_a = !ReqA;
  assign w_release_b = !ReqB;
`endif

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_rr_next    = r_rr;
    case (r_state)
      ST_IDLE: begin
        if (ReqA || ReqB) begin
          if (w_winner == r_sel) begin
            // Mux already points at the winner: grant without a dead cycle.
            w_state_next = w_winner ? ST_GNT_B : ST_GNT_A;
            w_rr_next    = ~w_winner;
          end else begin
            w_state_next = ST_SWITCH;
            w_sel_next   = w_winner;
          end
        end
      end
      ST_SWITCH: begin
        // Committed: grant whoever Sel now points at, even if it let go.
        w_state_next = r_sel ? ST_GNT_B : ST_GNT_A;
        w_rr_next    = ~r_sel;
      end
      ST_GNT_A: begin
        if (w_release_a) begin
          if (ReqB) begin
            w_state_next = ST_SWITCH;
            w_sel_next   = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_GNT_B: begin
        if (w_release_b) begin
          if (ReqA) begin
            w_state_next = ST_SWITCH;
            w_sel_next   = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they change on the
  // same edge as the state, with no combinational path to the pins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_rr    <= 1'b0;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_rr    <= w_rr_next;
      r_gnt_a <= (w_state_next == ST_GNT_A);
      r_gnt_b <= (w_state_next == ST_GNT_B);
      r_busy  <= (w_state_next == ST_GNT_A) || (w_state_next == ST_GNT_B);
    end
  end

  assign GntA = r_gnt_a;
  assign GntB = r_gnt_b;
  assign Sel  = r_sel;
  assign Busy = r_busy;

endmodule
